// File: rtl/w_buffer_loader.sv
// Weight buffer loader: reads packed weight words from BRAM and writes them,
// one weight per cycle and bank-major, into the per-column weight RAM banks.
module w_buffer_loader #(
   parameter int unsigned RAM_SIZE        = 1 << 8,
   parameter int unsigned ADDR_WIDTH      = $clog2(RAM_SIZE),
   parameter int unsigned ARRAY_M         = 8,
   parameter int unsigned WGT_WIDTH       = 8,
   parameter int unsigned BRAM_DATA_WIDTH = 32,
   parameter int unsigned BRAM_ADDR_WIDTH = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [$clog2(ARRAY_M):0]   num_cols,
   input  logic [ADDR_WIDTH:0]        depth,
   input  logic [BRAM_ADDR_WIDTH-1:0] src_base,
   input  logic [ADDR_WIDTH-1:0]      dst_base,
   output logic                       bram_en,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
   input  logic [BRAM_DATA_WIDTH-1:0] bram_rdata,
   output logic [ADDR_WIDTH-1:0]      bram_to_ram_w_addr,
   output logic [ARRAY_M-1:0]         bram_to_ram_w_en,
   output logic [WGT_WIDTH-1:0]       bram_to_ram_w_data,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned WPW    = BRAM_DATA_WIDTH / WGT_WIDTH;
   localparam int unsigned NC_W   = $clog2(ARRAY_M) + 1;
   localparam int unsigned D_W    = ADDR_WIDTH + 1;
   localparam int unsigned N_W    = NC_W + D_W;
   localparam int unsigned LANE_W = (WPW > 1) ? $clog2(WPW) : 1;
   localparam int unsigned BANK_W = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;

   state_t                     state;
   logic [BRAM_DATA_WIDTH-1:0] word_q;
   logic [D_W-1:0]             depth_q;
   logic [ADDR_WIDTH-1:0]      dst_q;
   logic [N_W-1:0]             rem_q;
   logic [LANE_W-1:0]          lane_q;
   logic [BANK_W-1:0]          bank_q;
   logic [D_W-1:0]             off_q;

   logic [NC_W-1:0]            cols_eff;
   logic [N_W-1:0]             n_total;
   logic [LANE_W-1:0]          nxt_lane;
   logic                       lane_last;
   logic                       do_issue;
   logic [WGT_WIDTH-1:0]       issue_data;

   always_comb begin
      cols_eff  = (num_cols > NC_W'(ARRAY_M)) ? NC_W'(ARRAY_M) : num_cols;
      n_total   = N_W'(cols_eff) * N_W'(depth);
      nxt_lane  = lane_q + LANE_W'(1);
      lane_last = (lane_q == LANE_W'(WPW - 1));
      // rem_q counts elements not yet presented on the write port
      do_issue  = (state == S_CAPTURE) ||
                  ((state == S_WRITE) && (rem_q != '0) && !lane_last);
      if (state == S_CAPTURE)
         issue_data = bram_rdata[WGT_WIDTH-1:0];
      else
         issue_data = WGT_WIDTH'(word_q >> (WGT_WIDTH * int'(nxt_lane)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= S_IDLE;
         bram_en            <= 1'b0;
         bram_addr          <= '0;
         bram_to_ram_w_addr <= '0;
         bram_to_ram_w_en   <= '0;
         bram_to_ram_w_data <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         word_q             <= '0;
         depth_q            <= '0;
         dst_q              <= '0;
         rem_q              <= '0;
         lane_q             <= '0;
         bank_q             <= '0;
         off_q              <= '0;
      end else begin
         bram_to_ram_w_en <= '0;
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  depth_q <= depth;
                  dst_q   <= dst_base;
                  rem_q   <= n_total;
                  bank_q  <= '0;
                  off_q   <= '0;
                  if (n_total == '0) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     bram_en   <= 1'b1;
                     bram_addr <= src_base;
                     busy      <= 1'b1;
                     state     <= S_READ;
                  end
               end
            end
            S_READ: begin
               bram_en <= 1'b0;
               state   <= S_CAPTURE;
            end
            S_CAPTURE: begin
               word_q <= bram_rdata;
               lane_q <= '0;
               state  <= S_WRITE;
            end
            S_WRITE: begin
               if (rem_q == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (lane_last) begin
                  bram_en   <= 1'b1;
                  bram_addr <= bram_addr + 1'b1;
                  state     <= S_READ;
               end else begin
                  lane_q <= nxt_lane;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // lane 0 is issued straight from bram_rdata so the first write lands
         // the cycle after CAPTURE; later lanes come from the word register
         if (do_issue) begin
            bram_to_ram_w_en   <= ARRAY_M'(1) << bank_q;
            bram_to_ram_w_addr <= dst_q + off_q[ADDR_WIDTH-1:0];
            bram_to_ram_w_data <= issue_data;
            rem_q              <= rem_q - N_W'(1);
            if (off_q == depth_q - D_W'(1)) begin
               off_q  <= '0;
               bank_q <= bank_q + BANK_W'(1);
            end else begin
               off_q <= off_q + D_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_w_buffer_loader.sv
// Randomized self-checking bench for w_buffer_loader with a cycle-indexed
// reference model derived from the element/word/timing arithmetic.
module tb_w_buffer_loader;

   localparam int AW  = 8;
   localparam int M   = 8;
   localparam int BAW = 12;
   localparam int WPW = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [3:0]     num_cols;
   logic [AW:0]    depth;
   logic [BAW-1:0] src_base;
   logic [AW-1:0]  dst_base;
   logic           bram_en;
   logic [BAW-1:0] bram_addr;
   logic [31:0]    bram_rdata;
   logic [AW-1:0]  w_addr;
   logic [M-1:0]   w_en;
   logic [7:0]     w_data;
   logic           busy;
   logic           done;

   w_buffer_loader #(
      .RAM_SIZE(256), .ARRAY_M(8), .WGT_WIDTH(8),
      .BRAM_DATA_WIDTH(32), .BRAM_ADDR_WIDTH(12)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .num_cols(num_cols),
      .depth(depth), .src_base(src_base), .dst_base(dst_base),
      .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
      .bram_to_ram_w_addr(w_addr), .bram_to_ram_w_en(w_en),
      .bram_to_ram_w_data(w_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (bram_en) bram_rdata <= mem[bram_addr];
      else         bram_rdata <= $urandom;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: command latched on acceptance, t = cycles since accept
   bit active = 1'b0;
   bit fresh  = 1'b1;
   int t, total, m_n, m_depth, m_src, m_dst;
   int cyc = 0, acc_cyc = 0, done_lat = -1;
   logic [23:0]    wlog[$];
   logic [BAW-1:0] rlog[$];

   always @(posedge clk) begin
      int cols;
      if (reset) begin
         active = 1'b0;
         fresh  = 1'b1;
      end else if (active) begin
         if (t == total) active = 1'b0;
         else t++;
      end else if (start) begin
         cols    = (num_cols > 8) ? 8 : int'(num_cols);
         m_depth = int'(depth);
         m_n     = cols * m_depth;
         m_src   = int'(src_base);
         m_dst   = int'(dst_base);
         total   = (m_n == 0) ? 1 : ((m_n + WPW - 1) / WPW) * 2 + m_n + 1;
         t       = 1;
         active  = 1'b1;
         fresh   = 1'b0;
         acc_cyc = cyc;
      end
      cyc++;
   end

   always @(negedge clk) begin
      int u, j, r, k;
      logic           e_ren, e_busy, e_done;
      logic [M-1:0]   e_wen;
      logic [BAW-1:0] e_raddr;
      logic [AW-1:0]  e_waddr;
      logic [31:0]    wd;
      logic [7:0]     e_wdata;
      e_ren = 0; e_busy = 0; e_done = 0; e_wen = '0;
      e_raddr = '0; e_waddr = '0; e_wdata = '0; wd = '0;
      if (active) begin
         if (t == total) e_done = 1;
         else begin
            e_busy = 1;
            u = t - 1;
            j = u / (WPW + 2);
            r = u % (WPW + 2);
            if (r == 0 && j * WPW < m_n) begin
               e_ren   = 1;
               e_raddr = BAW'((m_src + j) % 4096);
            end
            if (r >= 2) begin
               k = j * WPW + r - 2;
               if (k < m_n) begin
                  e_wen   = M'(1 << (k / m_depth));
                  e_waddr = AW'((m_dst + k % m_depth) % 256);
                  wd      = mem[(m_src + k / WPW) % 4096] >> (8 * (k % WPW));
                  e_wdata = wd[7:0];
               end
            end
         end
      end
      chk("ctrl{bram_en,busy,done,w_en}", {bram_en, busy, done, w_en}, {e_ren, e_busy, e_done, e_wen});
      if (e_ren) chk("bram_addr", bram_addr, e_raddr);
      if (e_wen != '0) chk("write{addr,data}", {w_addr, w_data}, {e_waddr, e_wdata});
      if (!active && fresh) chk("reset_values", {bram_addr, w_addr, w_data}, '0);
      if (bram_en)  rlog.push_back(bram_addr);
      if (|w_en)    wlog.push_back({w_en, w_addr, w_data});
      if (done)     done_lat = cyc - acc_cyc;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int nc, input int d, input int s, input int dst);
      wlog.delete();
      rlog.delete();
      done_lat = -1;
      num_cols = 4'(nc); depth = 9'(d); src_base = 12'(s); dst_base = 8'(dst);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic finish_cmd(input bit noise);
      for (int i = 0; i < 6000 && active; i++) begin
         if (noise) begin
            start    = 1'($urandom_range(0, 1));
            num_cols = 4'($urandom);
            depth    = 9'($urandom);
            src_base = 12'($urandom);
            dst_base = 8'($urandom);
         end
         step();
      end
      start = 1'b0;
      checks++;
      if (active) begin
         errors++;
         $display("FAIL timeout actual=busy expected=idle at %0t", $time);
      end
      step();
   endtask

   task automatic run_cmd(input int nc, input int d, input int s, input int dst, input bit noise);
      launch(nc, d, s, dst);
      finish_cmd(noise);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] wa [4];
      logic [23:0] e;
      reset = 1'b1; start = 1'b0;
      num_cols = '0; depth = '0; src_base = '0; dst_base = '0;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("idle_busy", busy, 1'b0);

      // two banks of depth 2 from one word, with start/param noise while busy
      mem[5] = 32'h44332211;
      run_cmd(2, 2, 5, 'h10, 1'b1);
      chk("t1_nwrites", wlog.size(), 4);
      chk("t1_w0", wlog[0], 24'h01_10_11);
      chk("t1_w1", wlog[1], 24'h01_11_22);
      chk("t1_w2", wlog[2], 24'h02_10_33);
      chk("t1_w3", wlog[3], 24'h02_11_44);
      chk("t1_nreads", rlog.size(), 1);
      chk("t1_raddr", rlog[0], 12'h005);
      chk("t1_latency", done_lat, 7);

      // partial last word
      mem['h20] = 32'h04030201;
      mem['h21] = 32'h08070605;
      run_cmd(2, 3, 'h20, 'h40, 1'b0);
      chk("t2_nwrites", wlog.size(), 6);
      chk("t2_w2", wlog[2], 24'h01_42_03);
      chk("t2_w3", wlog[3], 24'h02_40_04);
      chk("t2_w5", wlog[5], 24'h02_42_06);
      chk("t2_nreads", rlog.size(), 2);
      chk("t2_raddr1", rlog[1], 12'h021);
      chk("t2_latency", done_lat, 11);

      // bank address wrap
      run_cmd(1, 4, 'h30, 'hFE, 1'b0);
      wa = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      chk("t3_nwrites", wlog.size(), 4);
      for (int i = 0; i < 4; i++) begin
         e = wlog[i];
         chk("t3_waddr", e[15:8], wa[i]);
      end
      chk("t3_latency", done_lat, 7);

      // empty commands
      run_cmd(3, 0, 'h100, 0, 1'b0);
      chk("t4a_nwrites", wlog.size(), 0);
      chk("t4a_nreads", rlog.size(), 0);
      chk("t4a_latency", done_lat, 1);
      run_cmd(0, 5, 'h100, 0, 1'b1);
      chk("t4b_nwrites", wlog.size(), 0);
      chk("t4b_latency", done_lat, 1);

      // num_cols above ARRAY_M clamps to all eight banks
      run_cmd(9, 1, 'h40, 0, 1'b0);
      chk("t5_nwrites", wlog.size(), 8);
      e = wlog[7];
      chk("t5_lastbank", e[23:16], 8'h80);
      chk("t5_latency", done_lat, 13);

      // reset in the middle of WRITE, then a clean command
      launch(2, 4, 'h60, 'h20);
      for (int i = 0; i < 50 && wlog.size() < 2; i++) step();
      chk("t6_inwrite", w_en != '0, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("t6_busy_after_reset", busy, 1'b0);
      run_cmd(2, 4, 'h60, 'h20, 1'b0);
      chk("t6_nwrites", wlog.size(), 8);
      chk("t6_latency", done_lat, 2 * 2 + 8 + 1);

      // full-depth bank with BRAM address wrap
      run_cmd(1, 256, 'hFFE, 0, 1'b0);
      chk("t7_nreads", rlog.size(), 64);
      chk("t7_lastraddr", rlog[63], 12'h03D);
      chk("t7_latency", done_lat, 385);

      // randomized commands with occasional noise and mid-command reset
      for (int n = 0; n < 40; n++) begin
         launch($urandom_range(0, 12), $urandom_range(0, 24),
                $urandom_range(0, 4095), $urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(0, 20)) step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            step();
         end else begin
            finish_cmd(1'($urandom_range(0, 1)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
